// File: rtl/t01_button_ctrl.sv
// Button front end: per-button debounce, DAS/ARR repeat FSMs, and a
// priority-arbitrated single-entry command stage.
module t01_button_ctrl #(
  parameter int                 NUM_BTN         = 4,
  parameter int                 DEBOUNCE_CYCLES = 4,
  parameter int                 DAS_DELAY       = 10,
  parameter int                 ARR_PERIOD      = 3,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 4'b0011
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_BTN-1:0]         btn_sync,
  input  logic                       flush,
  input  logic                       cmd_ready,
  output logic                       cmd_valid,
  output logic [$clog2(NUM_BTN)-1:0] cmd_id,
  output logic [NUM_BTN-1:0]         held
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_MAX = (DAS_DELAY > ARR_PERIOD) ? DAS_DELAY : ARR_PERIOD;
  localparam int RP_W   = $clog2(RP_MAX + 1);
  localparam int ID_W   = $clog2(NUM_BTN);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, HOLD} rep_state_e;

  logic [NUM_BTN-1:0] deb_q, deb_d;
  logic [DB_W-1:0]    dcnt_q [NUM_BTN];
  logic [DB_W-1:0]    dcnt_d [NUM_BTN];
  rep_state_e         st_q   [NUM_BTN];
  rep_state_e         st_d   [NUM_BTN];
  logic [RP_W-1:0]    rcnt_q [NUM_BTN];
  logic [RP_W-1:0]    rcnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] evt;
  logic [NUM_BTN-1:0] pend_q, pend_d;
  logic               valid_q, valid_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               load;
  logic               found;
  logic [ID_W-1:0]    gnt_id;

  always_comb begin
    deb_d = deb_q;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      dcnt_d[i] = '0;
      if (btn_sync[i] != deb_q[i]) begin
        if (dcnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    evt = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      st_d[i]   = st_q[i];
      rcnt_d[i] = rcnt_q[i];
      case (st_q[i])
        IDLE: begin
          rcnt_d[i] = '0;
          if (deb_q[i]) begin
            evt[i]  = 1'b1;
            st_d[i] = REPEAT_MASK[i] ? DELAY : HOLD;
          end
        end
        DELAY: begin
          if (!deb_q[i]) begin
            st_d[i]   = IDLE;
            rcnt_d[i] = '0;
          end else if (rcnt_q[i] == RP_W'(DAS_DELAY - 1)) begin
            evt[i]    = 1'b1;
            st_d[i]   = REPEAT;
            rcnt_d[i] = '0;
          end else begin
            rcnt_d[i] = rcnt_q[i] + 1'b1;
          end
        end
        REPEAT: begin
          if (!deb_q[i]) begin
            st_d[i]   = IDLE;
            rcnt_d[i] = '0;
          end else if (rcnt_q[i] == RP_W'(ARR_PERIOD - 1)) begin
            evt[i]    = 1'b1;
            rcnt_d[i] = '0;
          end else begin
            rcnt_d[i] = rcnt_q[i] + 1'b1;
          end
        end
        HOLD: begin
          if (!deb_q[i]) begin
            st_d[i]   = IDLE;
            rcnt_d[i] = '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (pend_q[i] && !found) begin
        found  = 1'b1;
        gnt_id = ID_W'(i);
      end
    end
    load    = !valid_q || cmd_ready;
    pend_d  = pend_q | evt;
    valid_d = valid_q;
    id_d    = id_q;
    if (load) begin
      valid_d = found;
      if (found) begin
        id_d = gnt_id;
        // a fresh event on the granted button keeps its pending bit set
        pend_d[gnt_id] = evt[gnt_id];
      end
    end
    if (flush) begin
      pend_d  = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q   <= '0;
      pend_q  <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        dcnt_q[i] <= '0;
        rcnt_q[i] <= '0;
        st_q[i]   <= IDLE;
      end
    end else begin
      deb_q   <= deb_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        dcnt_q[i] <= dcnt_d[i];
        rcnt_q[i] <= rcnt_d[i];
        st_q[i]   <= st_d[i];
      end
    end
  end

  assign cmd_valid = valid_q;
  assign cmd_id    = id_q;
  assign held      = deb_q;

endmodule

// File: tb/tb_t01_button_ctrl.sv
module tb_t01_button_ctrl;

  localparam int NB   = 4;
  localparam int D    = 4;
  localparam int DAS  = 10;
  localparam int ARR  = 3;
  localparam logic [NB-1:0] MASK = 4'b0011;

  logic          clk;
  logic          rst;
  logic [NB-1:0] btn_sync;
  logic          flush;
  logic          cmd_ready;
  logic          cmd_valid;
  logic [1:0]    cmd_id;
  logic [NB-1:0] held;

  int nchk = 0;
  int nerr = 0;

  t01_button_ctrl #(
    .NUM_BTN(NB),
    .DEBOUNCE_CYCLES(D),
    .DAS_DELAY(DAS),
    .ARR_PERIOD(ARR),
    .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_sync(btn_sync),
    .flush(flush),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd_id(cmd_id),
    .held(held)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: level history, time since press, pending set, output slot.
  logic [NB-1:0] m_deb;
  logic [D-1:0]  m_hist [NB];
  int            m_age  [NB];
  logic [NB-1:0] m_pend;
  logic          m_valid;
  int            m_id;

  function automatic void model_reset();
    m_deb   = '0;
    m_pend  = '0;
    m_valid = 1'b0;
    m_id    = 0;
    for (int i = 0; i < NB; i++) begin
      m_hist[i] = '0;
      m_age[i]  = 0;
    end
  endfunction

  function automatic void model_step();
    logic [NB-1:0] ev;
    int  first;
    ev = '0;
    for (int i = 0; i < NB; i++) begin
      if (m_deb[i]) begin
        if (m_age[i] == 0)
          ev[i] = 1'b1;
        else if (MASK[i] && m_age[i] >= DAS && (m_age[i] - DAS) % ARR == 0)
          ev[i] = 1'b1;
      end
    end
    first = -1;
    for (int i = NB - 1; i >= 0; i--)
      if (m_pend[i]) first = i;
    if (!m_valid || cmd_ready) begin
      if (first >= 0) begin
        m_valid       = 1'b1;
        m_id          = first;
        m_pend[first] = 1'b0;
      end else begin
        m_valid = 1'b0;
      end
    end
    m_pend = m_pend | ev;
    if (flush) begin
      m_pend  = '0;
      m_valid = 1'b0;
    end
    for (int i = 0; i < NB; i++) begin
      if (m_deb[i]) m_age[i]++;
      m_hist[i] = {m_hist[i][D-2:0], btn_sync[i]};
      if (m_hist[i] == {D{~m_deb[i]}}) begin
        m_deb[i] = ~m_deb[i];
        m_age[i] = 0;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic ev, input int eid, input logic [NB-1:0] eh);
    chk({tag, " valid"}, int'(cmd_valid), int'(ev));
    if (ev) chk({tag, " id"}, int'(cmd_id), eid);
    chk({tag, " held"}, int'(held), int'(eh));
  endtask

  task automatic settle(input int n);
    btn_sync  = '0;
    cmd_ready = 1'b1;
    flush     = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  typedef struct {
    logic [NB-1:0] btn;
    logic          rdy;
    logic          fl;
    logic          exp_v;
    int            exp_id;
    logic [NB-1:0] exp_h;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [NB-1:0] b, input logic r, input logic f,
                              input logic ev, input int eid, input logic [NB-1:0] eh);
    vec_t v;
    v.btn = b; v.rdy = r; v.fl = f; v.exp_v = ev; v.exp_id = eid; v.exp_h = eh;
    vecs.push_back(v);
  endfunction

  initial begin
    logic ev;
    logic [NB-1:0] eh;

    // glitch on button 0, then a short press of button 1
    for (int c = 0; c < 3; c++) add(4'b0001, 1'b1, 1'b0, 1'b0, 0, 4'b0000);
    for (int c = 0; c < 7; c++) add(4'b0000, 1'b1, 1'b0, 1'b0, 0, 4'b0000);
    for (int r = 0; r < 18; r++)
      add((r < 8) ? 4'b0010 : 4'b0000, 1'b1, 1'b0, r == 6, 1,
          (r >= 4 && r < 12) ? 4'b0010 : 4'b0000);

    model_reset();
    rst = 1'b1; btn_sync = '0; flush = 1'b0; cmd_ready = 1'b1;
    tick(); tick();
    #2 rst = 1'b0;
    chk("reset valid", int'(cmd_valid), 0);
    chk("reset id", int'(cmd_id), 0);
    chk("reset held", int'(held), 0);

    for (int k = 0; k < vecs.size(); k++) begin
      btn_sync = vecs[k].btn; cmd_ready = vecs[k].rdy; flush = vecs[k].fl;
      check_out($sformatf("vec%0d", k), vecs[k].exp_v, vecs[k].exp_id, vecs[k].exp_h);
      tick();
    end
    settle(5);

    for (int c = 0; c < 41; c++) begin
      btn_sync = (c < 30) ? 4'b0001 : 4'b0000;
      ev = (c == 6) || (c >= 16 && c <= 34 && (c - 16) % 3 == 0);
      eh = (c >= 4 && c < 34) ? 4'b0001 : 4'b0000;
      check_out($sformatf("repeat c%0d", c), ev, 0, eh);
      tick();
    end
    settle(15);

    for (int c = 0; c < 41; c++) begin
      btn_sync = (c < 30) ? 4'b1000 : 4'b0000;
      eh = (c >= 4 && c < 34) ? 4'b1000 : 4'b0000;
      check_out($sformatf("nomask c%0d", c), c == 6, 3, eh);
      tick();
    end
    settle(15);

    for (int c = 0; c < 31; c++) begin
      btn_sync  = (c < 21) ? 4'b1100 : 4'b0000;
      cmd_ready = (c >= 15);
      eh = (c >= 4 && c < 25) ? 4'b1100 : 4'b0000;
      check_out($sformatf("arb c%0d", c), c >= 6 && c <= 16, (c <= 15) ? 2 : 3, eh);
      tick();
    end
    settle(15);

    for (int c = 0; c < 33; c++) begin
      btn_sync  = (c < 24) ? 4'b0101 : 4'b0000;
      cmd_ready = (c >= 9);
      flush     = (c == 8);
      ev = (c >= 6 && c <= 8) || (c >= 16 && c <= 28 && (c - 16) % 3 == 0);
      eh = (c >= 4 && c < 28) ? 4'b0101 : 4'b0000;
      check_out($sformatf("flush c%0d", c), ev, 0, eh);
      tick();
    end
    settle(15);

    for (int c = 0; c < 17; c++) begin
      btn_sync = 4'b0010;
      check_out($sformatf("prerst c%0d", c), c == 6 || c == 16, 1,
                (c >= 4) ? 4'b0010 : 4'b0000);
      if (c < 16) tick();
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("async rst valid", int'(cmd_valid), 0);
    chk("async rst id", int'(cmd_id), 0);
    chk("async rst held", int'(held), 0);
    tick();
    #2 rst = 1'b0;
    for (int c = 0; c < 13; c++) begin
      btn_sync = 4'b0010;
      check_out($sformatf("postrst c%0d", c), c == 6, 1, (c >= 4) ? 4'b0010 : 4'b0000);
      tick();
    end
    settle(15);

    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(0, 9) == 0) btn_sync[i] = ~btn_sync[i];
      cmd_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      chk("rand valid", int'(cmd_valid), int'(m_valid));
      if (m_valid) chk("rand id", int'(cmd_id), m_id);
      chk("rand held", int'(held), int'(m_deb));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
